instr_issue_queue: RTL and testbench
====================================

Name: instr_issue_queue

Overview:
Front-end fetch and issue buffer that sits directly upstream of the Tomasulo core and drives its `instr` input.
- Fetches words from a 1-cycle synchronous instruction memory into a circular queue.
- Presents the head instruction to the core.
- Holds the head while the reservation station for that instruction's class reports a stall.
- Supports a single-cycle redirect that flushes the queue and all in-flight fetches.

Parameters:
- DEPTH, 4, queue entries; must be a power of two ≥ 2.
- RESET_PC, 32'h0000_0000, fetch address after reset.
- NOP_INSTR, 32'h0000_0013, word driven on `instr` when the queue is empty (`addi x0,x0,0`).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  32  byte address of the request; bits [1:0] always 00.
- imem_rdata  in  32  fetched word; valid exactly one cycle after an accepted `imem_req`.
- A_stall  in  1  arithmetic reservation stations full.
- LS_stall  in  1  load/store buffer full.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored.
- instr  out  32  head instruction, or NOP_INSTR when the queue is empty.
- instr_valid  out  1  head entry present and not flushing.
- instr_pc  out  32  PC of the head entry; 0 when invalid.
- issue  out  1  head consumed this cycle.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- **Reset (asynchronous, immediate):**
  - `pc` = RESET_PC; `rd_ptr` = `wr_ptr` = 0; `count` = 0; `inflight` = 0.
  - `imem_req` = 0, `imem_addr` = RESET_PC, `instr` = NOP_INSTR, `instr_valid` = 0, `instr_pc` = 0, `issue` = 0.
- **Fetch:**
  - `imem_req` = !reset && !redirect_valid && (count + inflight) < DEPTH. Same-cycle pops are not credited.
  - `imem_addr` = `pc`.
  - On `imem_req`: `pc` += 4 (wraps modulo 2^32); `inflight` ← 1; `resp_pc` ← `pc`.
  - Otherwise `inflight` ← 0.
- **Response:**
  - When `inflight` = 1 and there is no redirect this cycle, write {`resp_pc`, `imem_rdata`} at `wr_ptr`, then `wr_ptr`++ modulo DEPTH.
  - At most one request is in flight per cycle, so back-to-back requests give one push per cycle.
- **Issue class decode on the head:**
  - `instr[6:0]` = 0000011 (load) or 0100011 (store) selects `LS_stall`.
  - Any other opcode selects `A_stall`.
- **Issue handshake:**
  - `issue` = `instr_valid` && !selected_stall.
  - On `issue`: `rd_ptr`++ modulo DEPTH.
  - The core samples `instr` on the same edge; the next entry is visible the following cycle.
- **Latency:** a request at cycle t pushes at the t+1 edge and appears on `instr` at t+2. Steady-state throughput is 1 instr/cycle with no stalls.
- **Count:**
  - push only → +1; pop only → −1; push and pop together → unchanged.
  - `count` never exceeds DEPTH; the credit check guarantees that a push never meets a full queue.
- **Empty:** `instr_valid` = 0, `instr` = NOP_INSTR, `issue` = 0. There is no bypass from `imem_rdata` to `instr`.
- **Redirect (priority over everything except reset):**
  - During the redirect cycle: `instr_valid` = 0, `issue` = 0, `imem_req` = 0.
  - At the edge: `count`, `rd_ptr`, `wr_ptr` ← 0; `inflight` ← 0; `pc` ← {redirect_pc[31:2], 2'b00}.
  - A response to a request issued in the redirect cycle or the cycle before is discarded.
  - The first request at the new PC is made in the cycle after redirect.
- **Both stalls high:** the head is held indefinitely and fetch continues until the queue is full.

Decomposition:
- **Shared package:** OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, NOP_INSTR, and a packed struct `iq_entry_t` {pc[31:0], instr[31:0]}.
- **Sub-module `iq_ring_buffer`:**
  - Holds DEPTH × `iq_entry_t` with pointers, count, push, pop and flush.
  - Asynchronous reset.
  - The top level keeps the fetch PC, in-flight tracking, class decode and issue logic.

Test Plan:
1. Release reset; imem returns word = addr ^ 32'hA5A5_0000; stalls low → first `instr_valid` 2 cycles after the first `imem_req`, with `instr_pc` 0, 4, 8, 12… in consecutive cycles and `count` ≤ 1.
2. `A_stall` = 1 with all-ALU words → `count` reaches 4, `imem_req` drops to 0 and `imem_addr` holds 0x10. Release stall → four issues in order (PC 0..0xC), then fetch resumes at 0x10.
3. Head = 32'h0000_2003 (lw) with `A_stall` = 1, `LS_stall` = 0 → `issue` = 1. Same head with `LS_stall` = 1, `A_stall` = 0 → held, `issue` = 0.
4. Queue holds 3 entries with one in flight; pulse `redirect_valid` with `redirect_pc` = 0x103 → next cycle `count` = 0, `instr` = 0x0000_0013, `imem_req` = 1 at 0x100; the stale response never appears on `instr`.
5. Assert `reset` mid-cycle while `count` = 3 → `count`, `instr_valid` and `imem_req` go to 0 before the next clock edge. Deassert → fetch restarts at RESET_PC.
6. Issue 12 instructions with stall toggling every 2 cycles → `instr_pc` strictly increments by 4 across three pointer wrap-arounds, with no drops or duplicates.

Source files
------------

// File: rtl/instr_issue_queue_pkg.sv
// Shared types and constants for the instruction fetch/issue buffer.
package instr_issue_queue_pkg;

    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // One queued instruction together with the address it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } iq_entry_t;

    // Loads and stores are steered to the load/store buffer; everything else
    // goes to the arithmetic reservation stations.
    function automatic logic is_ls_op(input logic [31:0] word);
        return (word[6:0] == OP_LOAD) || (word[6:0] == OP_STORE);
    endfunction

endpackage

// File: rtl/iq_ring_buffer.sv
// Circular buffer of fetched instructions with push, pop and flush.
module iq_ring_buffer
    import instr_issue_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  iq_entry_t     i_push_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output iq_entry_t     o_head,
    output logic [CW-1:0] o_count,
    output logic          o_empty
);

    iq_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_push;
    logic w_pop;

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // Guards keep the occupancy consistent even if a caller misbehaves.
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !o_empty;

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Pointer and occupancy bookkeeping; flush empties the buffer in one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are only observed while occupied, so no reset.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/instr_issue_queue.sv
// Fetch and issue buffer feeding the Tomasulo core: fetches from a 1-cycle
// synchronous instruction memory, queues the words and presents the head
// instruction, holding it while its reservation-station class is stalled.
module instr_issue_queue #(
    parameter  int          DEPTH     = 4,
    parameter  logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter  logic [31:0] NOP_INSTR = instr_issue_queue_pkg::NOP_INSTR,
    localparam int          CW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [31:0]   imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          A_stall,
    input  logic          LS_stall,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic [31:0]   instr,
    output logic          instr_valid,
    output logic [31:0]   instr_pc,
    output logic          issue,
    output logic [CW-1:0] count
);

    import instr_issue_queue_pkg::iq_entry_t;
    import instr_issue_queue_pkg::is_ls_op;

    logic [31:0]   r_pc;
    logic [31:0]   r_resp_pc;
    logic          r_inflight;

    iq_entry_t     w_push_data;
    iq_entry_t     w_head;
    logic [CW-1:0] w_count;
    logic [CW:0]   w_credit;
    logic          w_empty;
    logic          w_req;
    logic          w_push;
    logic          w_pop;
    logic          w_valid;
    logic          w_sel_stall;
    logic          w_unused_pc_lsb;

    // Redirect targets are forced word aligned.
    assign w_unused_pc_lsb = ^redirect_pc[1:0];

    // An outstanding fetch already owns a slot, so it is counted against the
    // free space. Pops in the same cycle are deliberately not credited.
    assign w_credit = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_req    = !reset && !redirect_valid && (w_credit < (CW + 1)'(DEPTH));

    // A response returning during a redirect belongs to the old path.
    assign w_push      = r_inflight && !redirect_valid;
    assign w_push_data = '{pc: r_resp_pc, instr: imem_rdata};

    // Head presentation and class-selected stall handshake.
    assign w_valid     = !w_empty && !redirect_valid;
    assign w_sel_stall = is_ls_op(w_head.instr) ? LS_stall : A_stall;
    assign w_pop       = w_valid && !w_sel_stall;

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign instr       = w_empty ? NOP_INSTR : w_head.instr;
    assign instr_valid = w_valid;
    assign instr_pc    = w_valid ? w_head.pc : 32'h0;
    assign issue       = w_pop;
    assign count       = w_count;

    iq_ring_buffer #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_empty     (w_empty)
    );

    // Fetch PC and in-flight tracking; redirect restarts fetch on the next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_inflight <= 1'b0;
        end else if (redirect_valid) begin
            r_pc       <= {redirect_pc[31:2], 2'b00};
            r_inflight <= 1'b0;
        end else if (w_req) begin
            r_pc       <= r_pc + 32'd4;
            r_inflight <= 1'b1;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    // Remember the address of the outstanding request to tag its response.
    always_ff @(posedge clk) begin
        if (w_req) begin
            r_resp_pc <= r_pc;
        end
    end

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed bench for instr_issue_queue with a 1-cycle instruction memory model.
module tb_instr_issue_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        A_stall;
    logic        LS_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic        issue;
    logic [2:0]  count;

    logic        word_mode;
    int          total = 0;
    int          bad   = 0;
    int          issued;
    logic [31:0] exp_pc;

    instr_issue_queue dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .A_stall        (A_stall),
        .LS_stall       (LS_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .instr_pc       (instr_pc),
        .issue          (issue),
        .count          (count)
    );

    always #5 clk = ~clk;

    // Instruction memory: word = addr ^ A5A5_0000, or a fixed lw in word_mode.
    always @(posedge clk) begin
        if (imem_req === 1'b1)
            imem_rdata <= word_mode ? 32'h0000_2003 : (imem_addr ^ 32'hA5A5_0000);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; A_stall = 1'b0; LS_stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; word_mode = 1'b0;
        #1;
        chk("rst_req",   32'(imem_req),    0);
        chk("rst_addr",  imem_addr,        0);
        chk("rst_instr", instr,            32'h0000_0013);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_pc",    instr_pc,         0);
        chk("rst_issue", 32'(issue),       0);
        chk("rst_count", 32'(count),       0);

        // Streaming fetch with no stalls
        cyc(); cyc(); reset = 1'b0; #1;
        chk("t1_req0",   32'(imem_req),    1);
        chk("t1_addr0",  imem_addr,        0);
        chk("t1_valid0", 32'(instr_valid), 0);
        cyc(); #1;
        chk("t1_addr1",  imem_addr,        4);
        chk("t1_valid1", 32'(instr_valid), 0);
        for (int i = 0; i < 6; i++) begin
            cyc(); #1;
            chk("t1_valid", 32'(instr_valid), 1);
            chk("t1_pc",    instr_pc,         32'(4 * i));
            chk("t1_instr", instr,            32'(4 * i) ^ 32'hA5A5_0000);
            chk("t1_count", 32'(count),       1);
            chk("t1_issue", 32'(issue),       1);
        end

        // Fill to DEPTH under A_stall, then drain in order
        reset = 1'b1; A_stall = 1'b1;
        cyc(); reset = 1'b0; #1;
        chk("t2_addr0", imem_addr, 0);
        cyc(); cyc(); #1;
        chk("t2_c2_issue", 32'(issue),    0);
        chk("t2_c2_pc",    instr_pc,      0);
        chk("t2_c2_addr",  imem_addr,     8);
        cyc(); #1;
        chk("t2_c3_count", 32'(count),    2);
        chk("t2_c3_req",   32'(imem_req), 1);
        cyc(); #1;
        chk("t2_c4_count", 32'(count),    3);
        chk("t2_c4_req",   32'(imem_req), 0);
        cyc(); cyc(); #1;
        chk("t2_full_count", 32'(count),    4);
        chk("t2_full_req",   32'(imem_req), 0);
        chk("t2_full_addr",  imem_addr,     32'h10);
        chk("t2_full_issue", 32'(issue),    0);
        cyc(); A_stall = 1'b0; #1;
        chk("t2_d0_issue", 32'(issue),    1);
        chk("t2_d0_pc",    instr_pc,      0);
        chk("t2_d0_req",   32'(imem_req), 0);
        cyc(); #1;
        chk("t2_d1_pc",    instr_pc,      4);
        chk("t2_d1_count", 32'(count),    3);
        chk("t2_d1_req",   32'(imem_req), 1);
        chk("t2_d1_addr",  imem_addr,     32'h10);
        cyc(); #1;
        chk("t2_d2_pc",    instr_pc,      8);
        chk("t2_d2_count", 32'(count),    2);
        cyc(); #1;
        chk("t2_d3_pc",    instr_pc,      32'hC);
        cyc(); #1;
        chk("t2_d4_pc",    instr_pc,      32'h10);
        chk("t2_d4_issue", 32'(issue),    1);

        // Class decode: lw follows LS_stall, not A_stall
        reset = 1'b1; A_stall = 1'b1; LS_stall = 1'b0; word_mode = 1'b1;
        cyc(); reset = 1'b0; #1;
        cyc(); cyc(); #1;
        chk("t3_instr",  instr,            32'h0000_2003);
        chk("t3_issue",  32'(issue),       1);
        cyc(); LS_stall = 1'b1; A_stall = 1'b0; #1;
        chk("t3_valid",  32'(instr_valid), 1);
        chk("t3_pc",     instr_pc,         4);
        chk("t3_hold",   32'(issue),       0);
        cyc(); #1;
        chk("t3_hold_pc", instr_pc,        4);
        chk("t3_hold2",   32'(issue),      0);

        // Redirect with three queued entries and one fetch in flight
        reset = 1'b1; A_stall = 1'b1; LS_stall = 1'b0; word_mode = 1'b0;
        cyc(); reset = 1'b0; #1;
        cyc(); cyc(); cyc(); cyc(); #1;
        chk("t4_pre_count", 32'(count), 3);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #1;
        chk("t4_rd_req",   32'(imem_req),    0);
        chk("t4_rd_valid", 32'(instr_valid), 0);
        chk("t4_rd_issue", 32'(issue),       0);
        cyc(); redirect_valid = 1'b0; #1;
        chk("t4_count", 32'(count),       0);
        chk("t4_instr", instr,            32'h0000_0013);
        chk("t4_valid", 32'(instr_valid), 0);
        chk("t4_req",   32'(imem_req),    1);
        chk("t4_addr",  imem_addr,        32'h100);
        cyc(); #1;
        chk("t4_stale_count", 32'(count), 0);
        chk("t4_addr2",       imem_addr,  32'h104);
        cyc(); #1;
        chk("t4_new_pc",    instr_pc,   32'h100);
        chk("t4_new_instr", instr,      32'hA5A5_0100);
        chk("t4_new_count", 32'(count), 1);

        // Asynchronous reset mid-cycle
        reset = 1'b1; A_stall = 1'b1;
        cyc(); reset = 1'b0; #1;
        cyc(); cyc(); cyc(); cyc(); #1;
        chk("t5_pre_count", 32'(count), 3);
        #2; reset = 1'b1; #1;
        chk("t5_count", 32'(count),       0);
        chk("t5_valid", 32'(instr_valid), 0);
        chk("t5_req",   32'(imem_req),    0);
        chk("t5_instr", instr,            32'h0000_0013);
        cyc(); reset = 1'b0; A_stall = 1'b0; #1;
        chk("t5_restart_req",  32'(imem_req), 1);
        chk("t5_restart_addr", imem_addr,     0);
        cyc(); cyc(); #1;
        chk("t5_first_pc", instr_pc, 0);

        // Twelve issues with A_stall toggling every 2 cycles
        reset = 1'b1;
        cyc(); reset = 1'b0;
        exp_pc = 32'h0; issued = 0;
        for (int k = 0; k < 200 && issued < 12; k++) begin
            A_stall = ((k / 2) % 2) == 1;
            #1;
            if (A_stall && instr_valid === 1'b1)
                chk("t6_hold", 32'(issue), 0);
            if (issue === 1'b1) begin
                chk("t6_pc",    instr_pc, exp_pc);
                chk("t6_instr", instr,    exp_pc ^ 32'hA5A5_0000);
                exp_pc = exp_pc + 32'd4;
                issued++;
            end
            cyc();
        end
        chk("t6_issued", 32'(issued), 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
